// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and default widths for the APB master arbiter
//
// Purpose: FSM state encoding, default bus widths and the grant index type
//          used by apb_master_arb, its interface and the rr_arb2 arbiter.
// Ports:   none (package).
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } state_e;

  // 0 = requester 0 (e.g. CPU), 1 = requester 1 (e.g. DMA)
  typedef logic gidx_t;

endpackage

// File: rtl/apb_master_arb_if.sv
// rtl/apb_master_arb_if.sv - requester and APB bus signal bundle
//
// Purpose: groups the two requester ports and the APB slave bus.
// Ports (signals):
//   req0/req1, wr0/wr1, addr0/addr1, wdata0/wdata1  requester inputs
//   done0/done1, rdata, err, tmo                    completion outputs
//   Paddr, Pwdata, Pwrite, Psel, Penable            APB master outputs
//   Prdata, Pready, Pslverr                         APB slave responses
// Modports: master = arbiter side, slave = requesters plus APB slave side.
interface apb_master_arb_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
);

  logic              req0;
  logic              req1;
  logic              wr0;
  logic              wr1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              tmo;
  logic [ADDR_W-1:0] Paddr;
  logic [DATA_W-1:0] Pwdata;
  logic              Pwrite;
  logic              Psel;
  logic              Penable;
  logic [DATA_W-1:0] Prdata;
  logic              Pready;
  logic              Pslverr;

  modport master (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
    input  Prdata, Pready, Pslverr,
    output done0, done1, rdata, err, tmo,
    output Paddr, Pwdata, Pwrite, Psel, Penable
  );

  modport slave (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
    output Prdata, Pready, Pslverr,
    input  done0, done1, rdata, err, tmo,
    input  Paddr, Pwdata, Pwrite, Psel, Penable
  );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter
//
// Purpose: combinational grant from the request vector and the last grant;
//          last grant is updated only when the grant is accepted.
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset (last grant resets to 1)
//   req_i[1:0]   eligible requests
//   accept_i     grant taken this cycle
//   gnt_o        granted index
//   gnt_valid_o  at least one request present
module rr_arb2
  import apb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output gidx_t      gnt_o,
  output logic       gnt_valid_o
);

  gidx_t last_q;
  gidx_t last_d;

  always_comb begin
    // on contention favour the requester that did not win last time
    gnt_o       = (req_i == 2'b11) ? ~last_q : req_i[1];
    gnt_valid_o = |req_i;
    last_d      = accept_i ? gnt_o : last_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// rtl/apb_master_arb.sv - two-requester APB master with round-robin arbitration
//
// Purpose: shares one APB slave bus between two requesters, runs the
//          SETUP/ACCESS sequence and aborts an ACCESS phase that waits
//          TIMEOUT cycles without Pready.
// Ports:
//   Pclk    APB clock, rising edge
//   Preset  asynchronous active-low reset
//   bus     apb_master_arb_if.master (requester ports and APB bus)
module apb_master_arb
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic            Pclk,
  input  logic            Preset,
  apb_master_arb_if.master bus
);

  localparam int             CW      = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT - 1);
  localparam logic [1:0]     S_IDLE   = IDLE;
  localparam logic [1:0]     S_SETUP  = SETUP;
  localparam logic [1:0]     S_ACCESS = ACCESS;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  gidx_t             gidx_q, gidx_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              err_q, err_d;
  logic              tmo_q, tmo_d;

  logic [1:0] elig;
  logic       accept;
  gidx_t      gnt;
  logic       gnt_valid;

  // a requester whose done is high this cycle still has req up; mask it so
  // the completed transfer is not granted a second time
  assign elig = {bus.req1 & ~done1_q, bus.req0 & ~done0_q};

  rr_arb2 u_arb (
    .clk_i       (Pclk),
    .rst_ni      (Preset),
    .req_i       (elig),
    .accept_i    (accept),
    .gnt_o       (gnt),
    .gnt_valid_o (gnt_valid)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gidx_d    = gidx_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    rdata_d   = rdata_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err_d     = 1'b0;
    tmo_d     = 1'b0;
    accept    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_valid) begin
          accept    = 1'b1;
          gidx_d    = gnt;
          paddr_d   = gnt ? bus.addr1  : bus.addr0;
          pwdata_d  = gnt ? bus.wdata1 : bus.wdata0;
          pwrite_d  = gnt ? bus.wr1    : bus.wr0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (bus.Pready) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          done0_d   = ~gidx_q;
          done1_d   = gidx_q;
          err_d     = bus.Pslverr;
          if (!pwrite_q) begin
            rdata_d = bus.Prdata;
          end
          state_d   = S_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          // slave never answered: release the bus and report the abort
          psel_d    = 1'b0;
          penable_d = 1'b0;
          done0_d   = ~gidx_q;
          done1_d   = gidx_q;
          err_d     = 1'b1;
          tmo_d     = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Pclk or negedge Preset) begin
    if (!Preset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      gidx_q    <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rdata_q   <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gidx_q    <= gidx_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      rdata_q   <= rdata_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

  assign bus.Paddr   = paddr_q;
  assign bus.Pwdata  = pwdata_q;
  assign bus.Pwrite  = pwrite_q;
  assign bus.Psel    = psel_q;
  assign bus.Penable = penable_q;
  assign bus.rdata   = rdata_q;
  assign bus.done0   = done0_q;
  assign bus.done1   = done1_q;
  assign bus.err     = err_q;
  assign bus.tmo     = tmo_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// tb/tb_apb_master_arb.sv - directed scoreboard bench for apb_master_arb
module tb_apb_master_arb;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_master_arb_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  apb_master_arb #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TMO)) dut (
    .Pclk   (clk),
    .Preset (rst_n),
    .bus    (bus.master)
  );

  typedef struct {
    int         port;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       wr;
    logic [7:0] rdata;
    logic       err;
    logic       tmo;
    int         psel_n;
    int         start;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  int         n_assert = 0;
  int         n_fail = 0;
  int         slave_wait = 0;
  logic [7:0] slave_rdata = 8'h00;
  logic       slave_err = 1'b0;
  int         acc_cyc = 0;
  logic [7:0] model_rd = 8'h00;

  // APB slave: Pready after slave_wait ACCESS cycles, never when negative
  always @(negedge clk) begin
    if (bus.Psel && bus.Penable) begin
      bus.Pready  = (acc_cyc == slave_wait);
      bus.Pslverr = (acc_cyc == slave_wait) && slave_err;
      bus.Prdata  = (acc_cyc == slave_wait) ? slave_rdata : 8'hEE;
      acc_cyc++;
    end else begin
      bus.Pready  = 1'b0;
      bus.Pslverr = 1'b0;
      bus.Prdata  = 8'hEE;
      acc_cyc = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int port, input logic wr, input logic [7:0] addr,
                      input logic [7:0] wdata, input int waits, input logic [7:0] rd,
                      input logic serr, input logic timed);
    exp_t e;
    e.port  = port;
    e.addr  = addr;
    e.wdata = wdata;
    e.wr    = wr;
    if (waits < 0) begin
      e.err    = 1'b1;
      e.tmo    = 1'b1;
      e.psel_n = 2 + (TMO - 1);
    end else begin
      if (!wr) model_rd = rd;
      e.err    = serr;
      e.tmo    = 1'b0;
      e.psel_n = 2 + waits;
    end
    e.rdata = model_rd;
    e.start = cyc;
    e.lat   = timed ? e.psel_n + 1 : -1;
    sb.push_back(e);
  endtask

  task automatic drive(input int port, input logic v, input logic wr,
                       input logic [7:0] addr, input logic [7:0] wdata);
    if (port == 0) begin
      bus.req0 = v; bus.wr0 = wr; bus.addr0 = addr; bus.wdata0 = wdata;
    end else begin
      bus.req1 = v; bus.wr1 = wr; bus.addr1 = addr; bus.wdata1 = wdata;
    end
  endtask

  task automatic xfer(input int port, input logic wr, input logic [7:0] addr,
                      input logic [7:0] wdata, input int waits, input logic [7:0] rd,
                      input logic serr);
    int   n;
    logic got;
    @(negedge clk);
    slave_wait = waits; slave_rdata = rd; slave_err = serr;
    drive(port, 1'b1, wr, addr, wdata);
    push(port, wr, addr, wdata, waits, rd, serr, 1'b1);
    n = 0; got = 1'b0;
    while (n < 40 && !got) begin
      @(negedge clk);
      got = (port == 0) ? bus.done0 : bus.done1;
      n++;
    end
    check("done_seen", {31'd0, got}, 32'd1);
    drive(port, 1'b0, wr, addr, wdata);
    repeat (2) @(negedge clk);
  endtask

  task automatic contend(input int n_each);
    int c0, c1, n;
    @(negedge clk);
    slave_wait = 0; slave_err = 1'b0; slave_rdata = 8'h00;
    drive(0, 1'b1, 1'b1, 8'h01, 8'h11);
    drive(1, 1'b1, 1'b1, 8'h02, 8'h22);
    for (int i = 0; i < n_each; i++) begin
      push(0, 1'b1, 8'h01, 8'h11, 0, 8'h00, 1'b0, 1'b0);
      push(1, 1'b1, 8'h02, 8'h22, 0, 8'h00, 1'b0, 1'b0);
    end
    c0 = 0; c1 = 0; n = 0;
    while ((c0 < n_each || c1 < n_each) && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.done0) begin c0++; if (c0 == n_each) bus.req0 = 1'b0; end
      if (bus.done1) begin c1++; if (c1 == n_each) bus.req1 = 1'b0; end
    end
    check("contend_cnt0", c0, n_each);
    check("contend_cnt1", c1, n_each);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    #1 rst_n = 1'b0;

    fork
      begin : monitor
        int         psel_n, pen_n;
        logic [7:0] seen_addr, seen_wdata;
        logic       seen_wr;
        exp_t       e;
        psel_n = 0; pen_n = 0;
        seen_addr = 8'h00; seen_wdata = 8'h00; seen_wr = 1'b0;
        forever begin
          @(negedge clk);
          if (rst_n) begin
            check("done_excl", {31'd0, bus.done0 & bus.done1}, 32'd0);
            if (!bus.Psel) check("penable_wo_psel", {31'd0, bus.Penable}, 32'd0);
            if (!(bus.done0 || bus.done1)) check("flags_idle", {30'd0, bus.err, bus.tmo}, 32'd0);
            if (bus.Psel && !bus.Penable) begin
              seen_addr = bus.Paddr; seen_wdata = bus.Pwdata; seen_wr = bus.Pwrite;
            end
            if (bus.Psel && bus.Penable) check("paddr_stable", bus.Paddr, seen_addr);
          end
          if (bus.done0 || bus.done1) begin
            if (sb.size() == 0) begin
              check("sb_underflow", 0, 1);
            end else begin
              e = sb.pop_front();
              check("port", bus.done1 ? 1 : 0, e.port);
              check("rdata", bus.rdata, e.rdata);
              check("err", bus.err, e.err);
              check("tmo", bus.tmo, e.tmo);
              check("addr", seen_addr, e.addr);
              check("wdata", seen_wdata, e.wdata);
              check("pwrite", seen_wr, e.wr);
              check("psel_cycles", psel_n, e.psel_n);
              check("penable_cycles", pen_n, e.psel_n - 1);
              if (e.lat >= 0) check("latency", cyc - e.start, e.lat);
            end
            psel_n = 0; pen_n = 0;
          end else if (bus.Psel) begin
            psel_n++;
            if (bus.Penable) pen_n++;
          end else begin
            psel_n = 0; pen_n = 0;
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    check("rst_psel", bus.Psel, 0);
    check("rst_penable", bus.Penable, 0);
    check("rst_done", {bus.done1, bus.done0}, 0);
    check("rst_flags", {bus.err, bus.tmo}, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_paddr", bus.Paddr, 0);
    check("rst_pwdata", bus.Pwdata, 0);
    check("rst_pwrite", bus.Pwrite, 0);
    rst_n = 1'b1;

    contend(2);
    xfer(0, 1'b1, 8'h3C, 8'hA5, 0, 8'h00, 1'b0);
    xfer(1, 1'b0, 8'h10, 8'h77, 3, 8'h5A, 1'b0);
    xfer(0, 1'b1, 8'hFF, 8'h33, 0, 8'h00, 1'b1);
    xfer(1, 1'b1, 8'h80, 8'h99, -1, 8'h00, 1'b0);
    check("idle_psel_after_tmo", bus.Psel, 0);
    check("idle_paddr_hold", bus.Paddr, 8'h80);
    xfer(0, 1'b0, 8'h21, 8'h00, 0, 8'hC3, 1'b0);
    xfer(1, 1'b0, 8'h22, 8'h00, 1, 8'h3D, 1'b0);

    // async reset in the middle of a wait state
    @(negedge clk);
    slave_wait = -1;
    drive(0, 1'b1, 1'b0, 8'h44, 8'h00);
    repeat (3) @(negedge clk);
    check("pre_rst_penable", bus.Penable, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_psel", bus.Psel, 0);
    check("arst_penable", bus.Penable, 0);
    check("arst_done", {bus.done1, bus.done0}, 0);
    drive(0, 1'b0, 1'b0, 8'h44, 8'h00);
    rst_n = 1'b1;
    model_rd = 8'h00;
    repeat (2) @(negedge clk);
    contend(1);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
